// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch direction predictor.
//   BP_MODE_*   : indexing mode selectors for the top-level MODE parameter
//   clog2       : ceiling log2, used to derive the table index width
//   sat_update  : one step of a saturating up/down counter of a given width
package branch_predictor_pkg;

  localparam int BP_MODE_BIMODAL = 0;
  localparam int BP_MODE_GSHARE  = 1;

  // Widest counter supported; narrower counters ride in the low bits.
  localparam int BP_CNT_MAX_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic logic [BP_CNT_MAX_W-1:0] sat_update(
    input logic [BP_CNT_MAX_W-1:0] cnt,
    input logic                    taken,
    input int                      width
  );
    logic [BP_CNT_MAX_W-1:0] max_val;
    max_val = BP_CNT_MAX_W'((1 << width) - 1);
    if (taken) begin
      return (cnt >= max_val) ? max_val : cnt + BP_CNT_MAX_W'(1);
    end
    return (cnt == '0) ? cnt : cnt - BP_CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_array.sv
// bp_sat_counter_array: pattern history table storage.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (entries -> weakly not-taken)
//   i_rd_idx     : asynchronous read index
//   o_rd_cnt     : counter value at i_rd_idx (pre-update value on a same-cycle write)
//   i_wr_en      : apply a saturating update at the clock edge
//   i_wr_idx     : entry to update
//   i_wr_taken   : 1 = increment toward all-ones, 0 = decrement toward zero
module bp_sat_counter_array
  import branch_predictor_pkg::*;
#(
  parameter  int PHT_DEPTH = 64,
  parameter  int CNT_W     = 2,
  localparam int IDX_W     = clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0] o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] r_cnt [PHT_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) r_cnt[i] <= CNT_INIT;
    end else if (i_wr_en) begin
      r_cnt[i_wr_idx] <= CNT_W'(sat_update(BP_CNT_MAX_W'(r_cnt[i_wr_idx]), i_wr_taken, CNT_W));
    end
  end

  // No bypass: a same-cycle write is visible only after the edge.
  assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: dynamic branch direction predictor (bimodal or gshare).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pred_valid_i      : lookup request this cycle
//   pred_pc_i         : fetch PC
//   pred_take_o       : predicted direction (combinational)
//   pred_idx_o        : table index used, carried down the pipe
//   pred_ghr_o        : history before this lookup, carried down the pipe
//   upd_valid_i       : a conditional branch resolved this cycle
//   upd_idx_i         : index returned from pred_idx_o
//   upd_ghr_i         : history snapshot returned from pred_ghr_o
//   upd_taken_i       : actual outcome
//   upd_mispredict_i  : outcome differs from prediction (qualified by upd_valid_i)
//   lookup_cnt_o      : saturating lookup count
//   mispred_cnt_o     : saturating mispredict count
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int PHT_DEPTH = 64,
  parameter  int CNT_W     = 2,
  parameter  int GHR_W     = 6,
  parameter  int MODE      = BP_MODE_BIMODAL,
  localparam int IDX_W     = clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  output logic             pred_take_o,
  output logic [IDX_W-1:0] pred_idx_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic             upd_mispredict_i,
  output logic [31:0]      lookup_cnt_o,
  output logic [31:0]      mispred_cnt_o
);

  logic [GHR_W-1:0] r_ghr;
  logic [31:0]      r_lookup_cnt;
  logic [31:0]      r_mispred_cnt;

  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_lookup_idx;
  logic [CNT_W-1:0] w_rd_cnt;
  logic             w_repair;
  logic             w_unused;

  assign w_pc_idx     = pred_pc_i[IDX_W+1:2];
  assign w_lookup_idx = (MODE == BP_MODE_GSHARE) ? (w_pc_idx ^ IDX_W'(r_ghr)) : w_pc_idx;
  assign w_repair     = upd_valid_i & upd_mispredict_i;
  assign w_unused     = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0], upd_ghr_i};

  bp_sat_counter_array #(
    .PHT_DEPTH (PHT_DEPTH),
    .CNT_W     (CNT_W)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_lookup_idx),
    .o_rd_cnt   (w_rd_cnt),
    .i_wr_en    (upd_valid_i),
    .i_wr_idx   (upd_idx_i),
    .i_wr_taken (upd_taken_i)
  );

  // Shifts are written as a truncating cast of {history, new_bit} so the
  // one-bit history case simply loads the new bit.
  always_ff @(posedge clk) begin
    if (rst || MODE != BP_MODE_GSHARE) begin
      r_ghr <= '0;
    end else if (w_repair) begin
      // Repair wins over a same-cycle lookup; that lookup is on the wrong path.
      r_ghr <= GHR_W'({upd_ghr_i, upd_taken_i});
    end else if (pred_valid_i) begin
      r_ghr <= GHR_W'({r_ghr, pred_take_o});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lookup_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (pred_valid_i && r_lookup_cnt != '1) r_lookup_cnt <= r_lookup_cnt + 32'd1;
      if (w_repair && r_mispred_cnt != '1)    r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign pred_take_o   = w_rd_cnt[CNT_W-1];
  assign pred_idx_o    = w_lookup_idx;
  assign pred_ghr_o    = r_ghr;
  assign lookup_cnt_o  = r_lookup_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench: one bimodal and one gshare instance share
// the same stimulus; each step checks the instance it targets.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic [5:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        bim_take, gsh_take;
  logic [5:0]  bim_idx, gsh_idx, bim_ghr, gsh_ghr;
  logic [31:0] bim_lcnt, gsh_lcnt, bim_mcnt, gsh_mcnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PHT_DEPTH(64), .CNT_W(2), .GHR_W(6), .MODE(0)) u_bim (
    .clk(clk), .rst(rst), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
    .pred_take_o(bim_take), .pred_idx_o(bim_idx), .pred_ghr_o(bim_ghr),
    .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr),
    .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict),
    .lookup_cnt_o(bim_lcnt), .mispred_cnt_o(bim_mcnt)
  );

  branch_predictor #(.PHT_DEPTH(64), .CNT_W(2), .GHR_W(6), .MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
    .pred_take_o(gsh_take), .pred_idx_o(gsh_idx), .pred_ghr_o(gsh_ghr),
    .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr),
    .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict),
    .lookup_cnt_o(gsh_lcnt), .mispred_cnt_o(gsh_mcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pred_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_ghr = '0;
    upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    tick();
    do_reset();

    // 1: reset state, bimodal lookup of 0x40
    pred_valid = 1'b1; pred_pc = 32'h40;
    settle();
    check("rst_take", 32'(bim_take), 32'd0);
    check("rst_idx", 32'(bim_idx), 32'd16);
    check("rst_lcnt", bim_lcnt, 32'd0);
    check("rst_mcnt", bim_mcnt, 32'd0);
    check("rst_gsh_ghr", 32'(gsh_ghr), 32'd0);
    check("rst_gsh_idx", 32'(gsh_idx), 32'd16);
    tick();
    pred_valid = 1'b0;
    check("lcnt_one", bim_lcnt, 32'd1);

    // 4: same-cycle lookup and taken update, counter 01
    pred_valid = 1'b1; pred_pc = 32'h40;
    upd_valid = 1'b1; upd_idx = 6'd16; upd_taken = 1'b1;
    settle();
    check("rw_same_cycle", 32'(bim_take), 32'd0);
    tick();
    upd_valid = 1'b0;
    settle();
    check("rw_next_cycle", 32'(bim_take), 32'd1);

    // 2: saturating counter walk on idx 16
    do_reset();
    upd_valid = 1'b1; upd_idx = 6'd16; upd_taken = 1'b1;
    tick(); tick();
    upd_valid = 1'b0; pred_valid = 1'b1; pred_pc = 32'h40;
    settle();
    check("two_taken", 32'(bim_take), 32'd1);
    upd_valid = 1'b1; upd_taken = 1'b1;
    tick(); tick(); tick();
    upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    settle();
    check("sat_hi_then_nt", 32'(bim_take), 32'd1);
    upd_valid = 1'b1; upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    settle();
    check("weak_nt", 32'(bim_take), 32'd0);
    upd_valid = 1'b1; upd_taken = 1'b0;
    tick(); tick(); tick();
    upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    settle();
    check("sat_lo_then_t", 32'(bim_take), 32'd0);
    upd_valid = 1'b1; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    settle();
    check("lo_climb", 32'(bim_take), 32'd1);

    // 3: gshare speculative history and repair
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pred_valid = 1'b1; pred_pc = 32'(i * 4);
      settle();
      check("gsh_nt_take", 32'(gsh_take), 32'd0);
      check("gsh_nt_ghr", 32'(gsh_ghr), 32'd0);
      tick();
    end
    pred_valid = 1'b0;
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_ghr = 6'b000011;
    upd_taken = 1'b1; upd_idx = 6'd3;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    settle();
    check("repair_ghr", 32'(gsh_ghr), 32'b000111);
    pred_valid = 1'b1; pred_pc = 32'h40;
    settle();
    check("gsh_xor_idx", 32'(gsh_idx), 32'd23);
    check("gsh_xor_take", 32'(gsh_take), 32'd0);
    pred_pc = 32'h10;
    settle();
    check("gsh_hit_idx", 32'(gsh_idx), 32'd3);
    check("gsh_hit_take", 32'(gsh_take), 32'd1);
    tick();
    check("spec_shift", 32'(gsh_ghr), 32'b001111);
    pred_pc = 32'h40;
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_ghr = 6'b101010;
    upd_taken = 1'b0; upd_idx = 6'd31;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0; pred_valid = 1'b0;
    settle();
    check("repair_wins", 32'(gsh_ghr), 32'b010100);
    check("gsh_lcnt", gsh_lcnt, 32'd6);
    check("gsh_mcnt", gsh_mcnt, 32'd2);
    upd_mispredict = 1'b1;
    tick();
    upd_mispredict = 1'b0;
    check("unqual_mis_ghr", 32'(gsh_ghr), 32'b010100);
    check("unqual_mis_cnt", gsh_mcnt, 32'd2);
    check("bim_ghr_zero", 32'(bim_ghr), 32'd0);

    // 5: reset mid-stream, update in reset cycle is dropped
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pred_valid = 1'b1; pred_pc = 32'h40;
      upd_valid = 1'b1; upd_idx = (i % 2 == 1) ? 6'd16 : 6'd5;
      upd_taken = 1'b1; upd_mispredict = 1'b1; upd_ghr = 6'h15;
      tick();
    end
    check("pre_rst_ghr", 32'(gsh_ghr), 32'h2B);
    check("pre_rst_lcnt", bim_lcnt, 32'd10);
    check("pre_rst_mcnt", bim_mcnt, 32'd10);
    upd_idx = 6'd16;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    pred_valid = 1'b1; pred_pc = 32'h40;
    settle();
    check("post_rst_take16", 32'(bim_take), 32'd0);
    pred_pc = 32'h14;
    settle();
    check("post_rst_take5", 32'(bim_take), 32'd0);
    check("post_rst_ghr", 32'(gsh_ghr), 32'd0);
    check("post_rst_lcnt", bim_lcnt, 32'd0);
    check("post_rst_mcnt", bim_mcnt, 32'd0);
    pred_valid = 1'b0;
    upd_valid = 1'b1; upd_idx = 6'd16; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0; pred_valid = 1'b1; pred_pc = 32'h40;
    settle();
    check("post_rst_weak", 32'(bim_take), 32'd1);

    // 6: statistics saturation
    pred_valid = 1'b0;
    u_bim.r_lookup_cnt  = 32'hFFFF_FFFE;
    u_bim.r_mispred_cnt = 32'hFFFF_FFFE;
    pred_valid = 1'b1;
    tick();
    check("lcnt_reach_max", bim_lcnt, 32'hFFFF_FFFF);
    tick(); tick();
    check("lcnt_hold_max", bim_lcnt, 32'hFFFF_FFFF);
    pred_valid = 1'b0;
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_idx = 6'd0;
    tick(); tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    check("mcnt_hold_max", bim_mcnt, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch direction predictor for the 5-stage MIPS pipeline. It replaces the static "branch resolved in decode" next-PC path. The predictor is looked up with the fetch PC, and the pipeline carries the returned index and history snapshot down to the stage where the branch resolves. The resolving stage sends back the outcome, which trains a table of saturating counters and, in gshare mode, repairs the global history on a mispredict.

Parameters:
PHT_DEPTH, 64, number of counter entries; power of 2, minimum 4.
CNT_W, 2, width of each saturating counter; 1 to 4.
GHR_W, 6, global history length; 1 to log2(PHT_DEPTH).
MODE, 0, 0 = bimodal (PC index only), 1 = gshare (PC index XOR history).
IDX_W, log2(PHT_DEPTH), derived; must not be overridden.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pred_valid_i  in  1  lookup request this cycle (fetch not stalled)
pred_pc_i  in  32  fetch PC
pred_take_o  out  1  predicted direction for pred_pc_i
pred_idx_o  out  IDX_W  table index used; pipelined alongside the branch
pred_ghr_o  out  GHR_W  history before this lookup; pipelined alongside the branch
upd_valid_i  in  1  a conditional branch resolved this cycle
upd_idx_i  in  IDX_W  index returned from pred_idx_o
upd_ghr_i  in  GHR_W  snapshot returned from pred_ghr_o
upd_taken_i  in  1  actual outcome
upd_mispredict_i  in  1  actual outcome differs from prediction; qualified by upd_valid_i
lookup_cnt_o  out  32  count of lookups
mispred_cnt_o  out  32  count of mispredicts

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high; every state element samples it on the rising edge of clk.
- Reset values:
  - All PHT entries = 2^(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2).
  - GHR = 0.
  - lookup_cnt_o = 0, mispred_cnt_o = 0.
  - pred_take_o after reset = 0 for every PC.
- Index computation:
  - pcidx = pred_pc_i[IDX_W+1:2].
  - MODE=0: idx = pcidx.
  - MODE=1: idx = pcidx XOR {zeros, GHR}.
- Lookup outputs: pred_take_o = MSB of PHT[idx]. Combinational, same-cycle read; zero latency for the fetch-stage mux. pred_ghr_o = current GHR.
- PHT update, on upd_valid_i at the clock edge:
  - If upd_taken_i: PHT[upd_idx_i] saturating-increments, capped at all-ones.
  - Otherwise: PHT[upd_idx_i] saturating-decrements, floored at 0.
- Same-cycle read and write: if a lookup and an update hit the same index in one cycle, the lookup returns the pre-update value. There is no write-to-read bypass. The update still lands at the edge.
- GHR, gshare mode (MODE=1), priority order at the clock edge:
  1. upd_valid_i & upd_mispredict_i: GHR <= {upd_ghr_i[GHR_W-2:0], upd_taken_i}. This is the repair and it overrides any same-cycle lookup shift; the wrong-path lookup is discarded by the pipeline flush.
  2. Else if pred_valid_i: GHR <= {GHR[GHR_W-2:0], pred_take_o}. This is the speculative shift.
  3. Else: GHR holds.
  - GHR_W=1: the shift degenerates to loading the new bit.
- GHR, bimodal mode (MODE=0): GHR is held at 0 and pred_ghr_o = 0.
- Statistics counters:
  - lookup_cnt_o increments on each pred_valid_i.
  - mispred_cnt_o increments on each upd_valid_i & upd_mispredict_i.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- upd_mispredict_i without upd_valid_i is ignored entirely.
- Reset asserted during operation: all state returns to reset values at that edge, regardless of pending lookups or updates. Updates presented in the reset cycle are dropped.
- No internal stall; the predictor accepts a lookup and an update every cycle.

Decomposition:
- Shared package holds:
  - Mode constants BP_MODE_BIMODAL = 0 and BP_MODE_GSHARE = 1.
  - Function sat_update(cnt, taken, width), used by the PHT.
  - Function clog2, used for IDX_W.
- One sub-module, bp_sat_counter_array: the PHT storage.
  - Parameters PHT_DEPTH and CNT_W.
  - One async read port and one sync write port with saturating update.
  - Reset-initialises all entries.
- GHR logic and statistics counters stay in the top module.

Test Plan:
1. Reset, then look up PC 0x0000_0040 in MODE=0 -> pred_take_o=0, pred_idx_o=16, both statistics counters =0.
2. MODE=0, CNT_W=2: two taken updates to idx 16 -> the following lookup of 0x40 gives pred_take_o=1. Three further taken updates -> counter stays 11. One not-taken update -> pred_take_o still 1 (counter 10).
3. MODE=1, GHR_W=6: four lookups predicted not-taken, then a mispredict update with upd_ghr_i=6'b000011 and taken=1 -> next pred_ghr_o=6'b000111. The mispredict and a concurrent lookup in the same cycle -> the repair wins.
4. Lookup and update to the same index in one cycle, counter 01, update taken -> pred_take_o=0 that cycle, 1 the next cycle.
5. Assert rst mid-stream after 10 updates -> the next cycle shows all counters weakly not-taken, GHR=0 and statistics =0. An update presented during the reset cycle has no effect.
6. Force lookup_cnt to 32'hFFFF_FFFE, then issue 3 lookups -> the counter reads 32'hFFFF_FFFF and holds.
